// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready flow control, synchronous flush
// and an optional two-entry skid buffer.
//
// SKID_EN=1: the main and skid entries together hold up to two payloads, and
//   in_ready comes straight from a register, so no combinational path runs
//   from out_ready to in_ready.
// SKID_EN=0: a single entry, with in_ready = ~out_valid | out_ready.
//
// Every empty entry holds RST_VALUE, so out_data is the bubble encoding
// whenever out_valid is low.
module pipe_stage_skid #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE  = {DATA_WIDTH{1'b0}},
  parameter bit                    SKID_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  // Main entry drives the outputs; the skid entry catches one extra payload
  // that arrives while main is stalled.
  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;

  logic accept;
  logic emit;

  // Upstream ready: registered in skid mode, combinational otherwise
  always_comb begin
    if (SKID_EN) begin
      in_ready = ~skid_valid_q;
    end else begin
      in_ready = ~main_valid_q | out_ready;
    end
  end

  assign accept = in_valid & in_ready;
  assign emit   = main_valid_q & out_ready;

  // Next-state selection for the main and skid entries
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (SKID_EN && skid_valid_q) begin
      // in_ready is low here, so no accept can coincide with the refill.
      if (emit) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_data_d  = RST_VALUE;
      end
    end else if (!main_valid_q || emit) begin
      // Main is free this cycle: take the new payload or fall back to a bubble.
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else if (emit) begin
        main_valid_d = 1'b0;
        main_data_d  = RST_VALUE;
      end
    end else if (SKID_EN && accept) begin
      // Main is stalled with a live payload: park the arrival in the skid.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // State registers; rst and flush_in both drop every entry
  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      main_valid_q <= 1'b0;
      main_data_q  <= RST_VALUE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= RST_VALUE;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. Both modes run side by side on the
// same input stimulus. Each mode has its own reference model: a FIFO queue of
// accepted payloads, bounded at two entries for skid mode and one otherwise.
module tb_pipe_stage_skid;

  localparam int unsigned W   = 32;
  localparam logic [W-1:0] RV = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst, flush_in, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_occ;
  logic         n_in_ready, n_out_valid;
  logic [W-1:0] n_out_data;
  logic [1:0]   n_occ;

  pipe_stage_skid #(.DATA_WIDTH(W), .RST_VALUE(RV), .SKID_EN(1'b1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .occupancy (s_occ)
  );

  pipe_stage_skid #(.DATA_WIDTH(W), .RST_VALUE(RV), .SKID_EN(1'b0)) u_noskid (
    .clk       (clk),
    .rst       (rst),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_ready  (n_in_ready),
    .in_data   (in_data),
    .out_valid (n_out_valid),
    .out_ready (out_ready),
    .out_data  (n_out_data),
    .occupancy (n_occ)
  );

  always #5 clk = ~clk;

  // Expected contents of each stage, oldest first
  logic [W-1:0] qs[$];
  logic [W-1:0] qn[$];
  logic         rdy_s = 1'b1;
  logic         rdy_n = 1'b1;
  bit           mon_en = 1'b0;
  int           checks = 0;
  int           failures = 0;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard push side: record every payload the model says was accepted
  always @(posedge clk) begin
    if (rst || flush_in) begin
      qs.delete();
      qn.delete();
    end else begin
      if (in_valid && rdy_s) qs.push_back(in_data);
      if (in_valid && rdy_n) qn.push_back(in_data);
    end
  end

  // Monitor: compare outputs away from the active edge, then retire emits
  always @(negedge clk) begin
    if (mon_en) begin
      rdy_s = (qs.size() < 2);
      cmp("skid out_valid", {31'b0, s_out_valid}, {31'b0, qs.size() != 0});
      cmp("skid out_data", s_out_data, (qs.size() != 0) ? qs[0] : RV);
      cmp("skid occupancy", {30'b0, s_occ}, qs.size());
      cmp("skid in_ready", {31'b0, s_in_ready}, {31'b0, rdy_s});
      if (qs.size() != 0 && out_ready) void'(qs.pop_front());

      rdy_n = (qn.size() == 0) || out_ready;
      cmp("noskid out_valid", {31'b0, n_out_valid}, {31'b0, qn.size() != 0});
      cmp("noskid out_data", n_out_data, (qn.size() != 0) ? qn[0] : RV);
      cmp("noskid occupancy", {30'b0, n_occ}, qn.size());
      cmp("noskid in_ready", {31'b0, n_in_ready}, {31'b0, rdy_n});
      if (qn.size() != 0 && out_ready) void'(qn.pop_front());
    end
  end

  // Apply one cycle of inputs, then step past the rising edge
  task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy,
                     input logic fl, input logic rs);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush_in  = fl;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1'b1, 32'hFFFF, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;

    // Streaming at full rate
    cyc(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Stall: 0xA in main, 0xB into skid, 0xC held upstream, then release
    cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush while full, with 0xD offered in the same cycle
    cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hD, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // out_ready toggles 1,0,1 with a live payload
    cyc(1'b1, 32'h21, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h23, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h24, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // rst together with flush_in while stalled at occupancy 1
    cyc(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h32, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Randomised valid/ready with rare flushes and resets
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 63) == 0), ($urandom_range(0, 255) == 0));
    end

    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
